dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller_if.sv | 37 +++
 rtl/dma_controller.sv | 161 ++++++++++++++++
 tb/tb_dma_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_if.sv
// ---------------------------------------------------------------------------
// dma_controller_if -- bus bundle between the DMA controller, the CPU bus
// arbiter, the external device and memory.
//   cmd       : {start address, length in words}, from the CPU
//   BG        : bus grant from the CPU
//   edata     : 4-word block from the external device, selected by offset
//   BR        : bus request to the CPU
//   READ      : transfer strobe, addr/data valid for a memory block write
//   addr      : memory word address of the current block
//   data      : current block (edata passed through)
//   offset    : device block index
//   interrupt : end-of-transfer pulse
// Modports: master = DMA controller side, slave = CPU/device/memory side.
// ---------------------------------------------------------------------------
interface dma_if #(
   parameter int unsigned WORD_SIZE = 16
) ();
   logic [2*WORD_SIZE-1:0] cmd;
   logic                   BG;
   logic [4*WORD_SIZE-1:0] edata;
   logic                   BR;
   logic                   READ;
   logic [WORD_SIZE-1:0]   addr;
   logic [4*WORD_SIZE-1:0] data;
   logic [1:0]             offset;
   logic                   interrupt;

   modport master (
      input  cmd, BG, edata,
      output BR, READ, addr, data, offset, interrupt
   );

   modport slave (
      output cmd, BG, edata,
      input  BR, READ, addr, data, offset, interrupt
   );
endinterface

// File: rtl/dma_controller.sv
// ---------------------------------------------------------------------------
// dma_controller -- moves a command-sized run of words from an external
// device to memory in 4-word blocks, each block held on the memory bus for
// BLOCK_LATENCY granted cycles.
//   CLK     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : dma_if.master (cmd/BG/edata in; BR/READ/addr/data/offset/
//             interrupt out)
// Optional feature: define DMA_CYCLE_STEAL_EN to drop BR for one cycle
// after every non-final block and re-request the bus for the next one.
// ---------------------------------------------------------------------------
module dma_controller #(
   parameter int unsigned WORD_SIZE     = 16,
   parameter int unsigned BLOCK_LATENCY = 4
) (
   input logic  CLK,
   input logic  reset_n,
   dma_if.master bus
);

   localparam int unsigned LEFT_W = WORD_SIZE - 1;
   localparam int unsigned SUM_W  = WORD_SIZE + 1;
   localparam int unsigned CNT_W  = (BLOCK_LATENCY > 1) ? $clog2(BLOCK_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LATENCY - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] REQ      = 3'd1;
   localparam logic [2:0] XFER     = 3'd2;
   localparam logic [2:0] DONE     = 3'd3;
   localparam logic [2:0] WAIT_CLR = 3'd4;
`ifdef DMA_CYCLE_STEAL_EN
   localparam logic [2:0] GAP      = 3'd5;
`endif

   logic [WORD_SIZE-1:0] cmd_start;
   logic [WORD_SIZE-1:0] cmd_len;
   logic [LEFT_W-1:0]    cmd_blocks;

   logic [2:0]           state_q, state_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [1:0]           off_q, off_d;
   logic [LEFT_W-1:0]    left_q, left_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 br_q;
   logic                 rd_q;
   logic                 irq_q;
   logic [WORD_SIZE-1:0] addr_out_q;
   logic [1:0]           off_out_q;

   assign cmd_start  = bus.cmd[2*WORD_SIZE-1:WORD_SIZE];
   assign cmd_len    = bus.cmd[WORD_SIZE-1:0];
   // ceil(len/4); widened by one bit so len near 2^WORD_SIZE cannot overflow
   assign cmd_blocks = LEFT_W'((SUM_W'(cmd_len) + SUM_W'(3)) >> 2);

   // Next-state and block bookkeeping
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      off_d   = off_q;
      left_d  = left_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_len != '0) begin
               addr_d  = cmd_start;
               off_d   = 2'd0;
               left_d  = cmd_blocks;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.BG) begin
               cnt_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (!bus.BG) begin
               // grant lost: the current block starts its hold over
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (left_q == LEFT_W'(1)) begin
                  state_d = DONE;
               end else begin
                  left_d = left_q - LEFT_W'(1);
                  off_d  = off_q + 2'd1;
                  addr_d = addr_q + WORD_SIZE'(4);
`ifdef DMA_CYCLE_STEAL_EN
                  state_d = GAP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = WAIT_CLR;
         end
         WAIT_CLR: begin
            // a held command must be withdrawn before it can start again
            if (cmd_len == '0) begin
               state_d = IDLE;
            end
         end
`ifdef DMA_CYCLE_STEAL_EN
         GAP: begin
            state_d = REQ;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and bookkeeping registers
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         off_q   <= 2'd0;
         left_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         left_q  <= left_d;
         cnt_q   <= cnt_d;
      end
   end

   // Registered bus outputs, decoded from the upcoming state
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         br_q       <= 1'b0;
         rd_q       <= 1'b0;
         irq_q      <= 1'b0;
         addr_out_q <= '0;
         off_out_q  <= 2'd0;
      end else begin
         br_q       <= (state_d == REQ) || (state_d == XFER);
         rd_q       <= (state_d == XFER);
         irq_q      <= (state_d == DONE);
         addr_out_q <= (state_d == XFER) ? addr_d : '0;
         off_out_q  <= (state_d == XFER) ? off_d : 2'd0;
      end
   end

   assign bus.BR        = br_q;
   // READ follows a grant withdrawal in the same cycle
   assign bus.READ      = rd_q & bus.BG;
   assign bus.addr      = addr_out_q;
   assign bus.offset    = off_out_q;
   assign bus.data      = rd_q ? bus.edata : '0;
   assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_dma_controller.sv
// ---------------------------------------------------------------------------
// tb_dma_controller -- self-checking bench for dma_controller. A CPU model
// grants the bus one cycle after BR is seen; a device model returns a block
// tagged with its offset. Expected blocks are queued when a command is
// issued and popped when the DUT completes a full BLOCK_LATENCY hold.
// ---------------------------------------------------------------------------
module tb_dma_controller;
   localparam int unsigned W   = 16;
   localparam int unsigned LAT = 4;

   typedef struct {
      logic [W-1:0] addr;
      logic [1:0]   off;
   } blk_t;

   logic CLK;
   logic reset_n;

   dma_if #(.WORD_SIZE(W)) bus ();

   dma_controller #(.WORD_SIZE(W), .BLOCK_LATENCY(LAT)) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int     vec = 0;
   int     errs = 0;
   blk_t   exp_q[$];
   int     read_cycles = 0;
   int     irq_count = 0;
   logic   br_last = 1'b0;
   logic   bg_block = 1'b0;
   int     run = 0;
   logic [W-1:0] run_addr = '0;
   logic [1:0]   run_off = 2'd0;
   bit     track_gaps = 1'b0;
   int     br_low_len = 0;
   int     gaps[$];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [4*W-1:0] dev_block(input logic [1:0] off);
      return {8'hD3, 6'd0, off, 8'hD2, 6'd0, off, 8'hD1, 6'd0, off, 8'hD0, 6'd0, off};
   endfunction

   assign bus.edata = dev_block(bus.offset);

   // CPU model: grant mirrors the request seen one cycle earlier
   initial begin
      bus.BG = 1'b0;
      forever begin
         @(posedge CLK);
         #2;
         bus.BG = bg_block ? 1'b0 : br_last;
      end
   end

   // Monitor / scoreboard consumer
   initial begin
      forever begin
         @(negedge CLK);
         br_last = bus.BR;
         if (reset_n !== 1'b1) begin
            run = 0;
            continue;
         end
         if (track_gaps) begin
            if (bus.BR === 1'b1) begin
               if (br_low_len > 0) gaps.push_back(br_low_len);
               br_low_len = 0;
            end else begin
               br_low_len++;
            end
         end
         if (bus.interrupt === 1'b1) begin
            irq_count++;
            vec++;
            if (bus.BR !== 1'b0 || bus.READ !== 1'b0) begin
               errs++;
               $display("FAIL irq_bus: BR=%b READ=%b during interrupt, required 0 0", bus.BR, bus.READ);
            end
         end
         if (bus.READ === 1'b1) begin
            read_cycles++;
            if (run != 0 && (bus.addr !== run_addr || bus.offset !== run_off)) run = 0;
            if (run == 0) begin
               run_addr = bus.addr;
               run_off  = bus.offset;
            end
            run++;
            if (run == LAT) begin
               vec++;
               if (exp_q.size() == 0) begin
                  errs++;
                  $display("FAIL block_unexpected: addr=%h off=%0d, required no block", bus.addr, bus.offset);
               end else begin
                  blk_t e;
                  e = exp_q.pop_front();
                  if (bus.addr !== e.addr || bus.offset !== e.off || bus.data !== dev_block(e.off)) begin
                     errs++;
                     $display("FAIL block_check: addr=%h off=%0d data=%h, required addr=%h off=%0d data=%h",
                              bus.addr, bus.offset, bus.data, e.addr, e.off, dev_block(e.off));
                  end
               end
            end else if (run == LAT + 1) begin
               vec++;
               errs++;
               $display("FAIL block_overhold: addr=%h held %0d cycles, required %0d", bus.addr, run, LAT);
            end
         end else begin
            run = 0;
         end
      end
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic push_xfer(input logic [31:0] c);
      logic [15:0] st;
      logic [15:0] len;
      int          n;
      st  = c[31:16];
      len = c[15:0];
      n   = (int'(len) + 3) / 4;
      for (int k = 0; k < n; k++) begin
         blk_t b;
         b.addr = st + 16'(4 * k);
         b.off  = 2'(k);
         exp_q.push_back(b);
      end
   endtask

   task automatic wait_irq(input int start, input string name);
      int n;
      n = 0;
      while (irq_count == start && n < 300) begin
         step();
         n++;
      end
      vec++;
      if (irq_count == start) begin
         errs++;
         $display("FAIL %s_irq: no interrupt after %0d cycles, required one", name, n);
      end
   endtask

   task automatic wait_block(input logic [1:0] off, input string name);
      int n;
      n = 0;
      while (!(bus.READ === 1'b1 && bus.offset === off) && n < 200) begin
         step();
         n++;
      end
      vec++;
      if (!(bus.READ === 1'b1 && bus.offset === off)) begin
         errs++;
         $display("FAIL %s_wait_block: block %0d never strobed, required it", name, off);
      end
   endtask

   task automatic check_q_empty(input string name);
      vec++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL %s_pending: %0d blocks outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_idle_zero(input string name);
      vec++;
      if ({bus.BR, bus.READ, bus.interrupt, bus.offset, bus.addr, bus.data} !== '0) begin
         errs++;
         $display("FAIL %s_idle_outputs: BR=%b READ=%b irq=%b off=%0d addr=%h data=%h, required all 0",
                  name, bus.BR, bus.READ, bus.interrupt, bus.offset, bus.addr, bus.data);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      bus.cmd  = '0;
      bg_block = 1'b0;
      repeat (3) step();
      check_idle_zero("reset");
      reset_n = 1'b1;
      repeat (3) step();
      check_idle_zero("post_reset");
   endtask

   task automatic test_basic();
      int r0, i0;
      r0 = read_cycles;
      i0 = irq_count;
      bus.cmd = 32'h0100000C;
      push_xfer(32'h0100000C);
      step();
      vec++;
      if (bus.BR !== 1'b1) begin
         errs++;
         $display("FAIL basic_br_rise: BR=%b, required 1", bus.BR);
      end
      gaps.delete();
      br_low_len = 0;
      track_gaps = 1'b1;
      wait_irq(i0, "basic");
      track_gaps = 1'b0;
      repeat (3) step();
      vec++;
      if (read_cycles - r0 != 12) begin
         errs++;
         $display("FAIL basic_read_cycles: %0d, required 12", read_cycles - r0);
      end
      vec++;
      if (irq_count - i0 != 1) begin
         errs++;
         $display("FAIL basic_irq_width: %0d cycles, required 1", irq_count - i0);
      end
      check_q_empty("basic");
      check_idle_zero("basic_wait_clr");
      vec++;
`ifdef DMA_CYCLE_STEAL_EN
      if (!(gaps.size() == 2 && gaps[0] == 1 && gaps[1] == 1)) begin
         errs++;
         $display("FAIL basic_br_gaps: %0d gaps, required two 1-cycle gaps", gaps.size());
      end
`else
      if (gaps.size() != 0) begin
         errs++;
         $display("FAIL basic_br_gaps: %0d gaps, required 0", gaps.size());
      end
`endif
   endtask

   task automatic test_held_cmd();
      int r0, i0;
      r0 = read_cycles;
      i0 = irq_count;
      repeat (20) step();
      vec++;
      if (read_cycles != r0 || irq_count != i0 || bus.BR !== 1'b0) begin
         errs++;
         $display("FAIL held_retrigger: reads=%0d irqs=%0d BR=%b, required 0 0 0",
                  read_cycles - r0, irq_count - i0, bus.BR);
      end
      bus.cmd = 32'h01000000;
      repeat (4) step();
      vec++;
      if (bus.BR !== 1'b0) begin
         errs++;
         $display("FAIL zero_len_start: BR=%b, required 0", bus.BR);
      end
      bus.cmd = 32'h0100000C;
      push_xfer(32'h0100000C);
      wait_irq(i0, "held_rearm");
      repeat (2) step();
      check_q_empty("held_rearm");
      bus.cmd = '0;
      repeat (2) step();
   endtask

   task automatic test_partial();
      int r0, i0;
      r0 = read_cycles;
      i0 = irq_count;
      bus.cmd = 32'h01F00005;
      push_xfer(32'h01F00005);
      wait_irq(i0, "partial");
      repeat (2) step();
      check_q_empty("partial");
      vec++;
      if (read_cycles - r0 != 8) begin
         errs++;
         $display("FAIL partial_read_cycles: %0d, required 8", read_cycles - r0);
      end
      bus.cmd = '0;
      repeat (2) step();
   endtask

   task automatic test_grant_gap();
      int r0, i0;
      r0 = read_cycles;
      i0 = irq_count;
      bus.cmd = 32'h0100000C;
      push_xfer(32'h0100000C);
      wait_block(2'd1, "gap");
      step();
      bg_block = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vec++;
         if (bus.READ !== 1'b0 || bus.BR !== 1'b1) begin
            errs++;
            $display("FAIL gap_withdraw: READ=%b BR=%b, required 0 1", bus.READ, bus.BR);
         end
      end
      bg_block = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         vec++;
         if (bus.READ !== 1'b1 || bus.offset !== 2'd1) begin
            errs++;
            $display("FAIL gap_rehold: READ=%b off=%0d, required 1 1", bus.READ, bus.offset);
         end
      end
      wait_irq(i0, "gap");
      repeat (2) step();
      check_q_empty("gap");
      // 12 cycles of completed holds plus the 2 cycles block 1 had before the gap
      vec++;
      if (read_cycles - r0 != 14) begin
         errs++;
         $display("FAIL gap_read_cycles: %0d, required 14", read_cycles - r0);
      end
      bus.cmd = '0;
      repeat (2) step();
   endtask

   task automatic test_reset_mid();
      int i0;
      i0 = irq_count;
      bus.cmd = 32'h0100000C;
      push_xfer(32'h0100000C);
      wait_block(2'd2, "rst_mid");
      reset_n = 1'b0;
      #1;
      check_idle_zero("rst_mid");
      vec++;
      if (exp_q.size() != 1) begin
         errs++;
         $display("FAIL rst_mid_progress: %0d blocks outstanding, required 1", exp_q.size());
      end
      exp_q.delete();
      repeat (3) step();
      vec++;
      if (irq_count != i0) begin
         errs++;
         $display("FAIL rst_mid_irq: %0d interrupts, required 0", irq_count - i0);
      end
      reset_n = 1'b1;
      step();
      vec++;
      if (bus.BR !== 1'b1) begin
         errs++;
         $display("FAIL rst_reaccept: BR=%b, required 1", bus.BR);
      end
      push_xfer(32'h0100000C);
      wait_irq(i0, "rst_reaccept");
      repeat (2) step();
      check_q_empty("rst_reaccept");
      bus.cmd = '0;
      repeat (2) step();
   endtask

   task automatic test_wrap();
      int r0, i0;
      r0 = read_cycles;
      i0 = irq_count;
      bus.cmd = 32'hFFFC0014;
      push_xfer(32'hFFFC0014);
      repeat (5) step();
      bus.cmd = 32'h12340000;
      wait_irq(i0, "wrap");
      repeat (3) step();
      check_q_empty("wrap");
      vec++;
      if (read_cycles - r0 != 20) begin
         errs++;
         $display("FAIL wrap_read_cycles: %0d, required 20", read_cycles - r0);
      end
      check_idle_zero("wrap_after");
      bus.cmd = '0;
      repeat (2) step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_held_cmd();
      test_partial();
      test_grant_gap();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
